// File: rtl/vga_game_pkg.sv
// Shared definitions for the VGA game timing/control slice: display timing
// range, default scheduler settings and the game run-state encoding.
package vga_game_pkg;

  localparam int VBLANK_LINE_DEF     = 516;
  localparam int TICK_DIV_DEF        = 1;
  localparam int DEBOUNCE_FRAMES_DEF = 2;

  // Counter values at or beyond these totals never come from a sane
  // display controller and are treated as noise.
  localparam int H_TOTAL = 800;
  localparam int V_TOTAL = 525;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_PAUSED = 2'd1,
    ST_STEP   = 2'd2
  } game_state_t;

  // True only for the first pixel of the vertical blanking line, and only
  // when both counters lie inside the display timing range.
  function automatic logic is_vblank_start(input logic [9:0] h,
                                           input logic [9:0] v,
                                           input int         vline);
    logic in_range;
    in_range = (int'(h) < H_TOTAL) && (int'(v) < V_TOTAL);
    return in_range && (h == 10'd0) && (v == vline[9:0]);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button: two-flop synchronizer followed by a debounce counter that
// only looks at the button once per frame.
module btn_debounce
  import vga_game_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = DEBOUNCE_FRAMES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  input  logic sample_en,
  output logic level
);

  localparam logic [2:0] CNT_TC = 3'(DEBOUNCE_FRAMES);

  logic       sync_q1;
  logic       sync_q2;
  logic [2:0] cnt;

  // Bring the asynchronous button into the clk domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= btn_raw;
      sync_q2 <= sync_q1;
    end
  end

  // Count consecutive frame samples that disagree with the stable level;
  // accept the new level once enough of them have been seen in a row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sample_en) begin
      if (sync_q2 == level) begin
        cnt <= '0;
      end else if (cnt + 3'd1 == CNT_TC) begin
        level <= sync_q2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 3'd1;
      end
    end
  end

endmodule

// File: rtl/game_tick_scheduler.sv
// Frame-rate scheduler for the game: one tick per frame at the start of
// vertical blanking, debounced buttons, a frame divider producing move
// opportunities and a RUN/PAUSED/STEP control FSM.
//
//   state  | meaning
//   RUN    | game advances on every move opportunity
//   PAUSED | game frozen, directions masked
//   STEP   | waiting for the next opportunity to advance exactly once
module game_tick_scheduler
  import vga_game_pkg::*;
#(
  parameter int VBLANK_LINE     = VBLANK_LINE_DEF,
  parameter int TICK_DIV        = TICK_DIV_DEF,
  parameter int DEBOUNCE_FRAMES = DEBOUNCE_FRAMES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] hCount,
  input  logic [9:0] vCount,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_center,
  output logic       frame_tick,
  output logic       move_en,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right,
  output logic       paused,
  output logic [7:0] frame_count
);

  localparam logic [3:0] DIV_LAST = 4'(TICK_DIV - 1);

  // Bit order: 0 up, 1 down, 2 left, 3 right, 4 center.
  logic [4:0]  btn_raw;
  logic [4:0]  btn_lvl;
  logic        center_lvl_q;
  logic        right_lvl_q;
  logic        center_press;
  logic        right_press;
  logic [3:0]  div_cnt;
  logic        move_opp;
  game_state_t state;
  game_state_t state_nxt;

  assign btn_raw = {btn_center, btn_right, btn_left, btn_down, btn_up};

  for (genvar i = 0; i < 5; i++) begin : g_btn
    btn_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_btn_debounce (
      .clk       (clk),
      .rst       (rst),
      .btn_raw   (btn_raw[i]),
      .sample_en (frame_tick),
      .level     (btn_lvl[i])
    );
  end

  // One-cycle tick on the cycle after the blanking start pixel is seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) frame_tick <= 1'b0;
    else     frame_tick <= is_vblank_start(hCount, vCount, VBLANK_LINE);
  end

  // Free-running frame counter, independent of the game state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             frame_count <= '0;
    else if (frame_tick) frame_count <= frame_count + 8'd1;
  end

  // Frame divider; the last frame of each group is a move opportunity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             div_cnt <= '0;
    else if (frame_tick) div_cnt <= (div_cnt == DIV_LAST) ? 4'd0 : div_cnt + 4'd1;
  end

  assign move_opp = frame_tick && (div_cnt == DIV_LAST);

  // Previous stable levels for rising-edge detection of the control buttons.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      center_lvl_q <= 1'b0;
      right_lvl_q  <= 1'b0;
    end else begin
      center_lvl_q <= btn_lvl[4];
      right_lvl_q  <= btn_lvl[3];
    end
  end

  assign center_press = btn_lvl[4] & ~center_lvl_q;
  assign right_press  = btn_lvl[3] & ~right_lvl_q;

  // Move enable follows an opportunity only if the game was not frozen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) move_en <= 1'b0;
    else     move_en <= move_opp && (state != ST_PAUSED);
  end

  // Control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_RUN;
    else     state <= state_nxt;
  end

  // Next-state logic; presses and opportunities never share a cycle, but
  // the opportunity is still given priority in STEP for clarity.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_RUN: begin
        if (center_press) state_nxt = ST_PAUSED;
      end
      ST_PAUSED: begin
        if (center_press)     state_nxt = ST_RUN;
        else if (right_press) state_nxt = ST_STEP;
      end
      ST_STEP: begin
        if (move_opp)          state_nxt = ST_PAUSED;
        else if (center_press) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  assign paused = (state == ST_PAUSED) || (state == ST_STEP);
  assign up     = btn_lvl[0] & ~paused;
  assign down   = btn_lvl[1] & ~paused;
  assign left   = btn_lvl[2] & ~paused;
  assign right  = btn_lvl[3] & ~paused;

endmodule
